mem_stage: RTL and testbench

Memory-stage controller sitting directly upstream of the load/store unit. Accepts one instruction at a time from the execute stage over a valid/ready handshake, checks address alignment, and drives the LSU request/response handshake. Forwards the load result, ALU result or exception to the writeback stage through a registered valid/ready output. Never aborts an LSU transaction once started; flushes discard results instead.

---
 rtl/mem_stage_pkg.sv | 48 ++++
 rtl/mem_align_chk.sv | 14 +
 rtl/mem_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_stage.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage and the load/store unit:
// RV64 load/store funct3 codes, misaligned-access cause codes and the
// memory-stage state encoding.
package mem_stage_pkg;

    localparam int XLEN_DEFAULT = 64;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Exception cause codes reported to writeback
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_OUT    = 2'd2
    } mem_state_e;

    // Address bits that must be zero for a naturally aligned access of the
    // size encoded in funct3. Store encodings share the low two bits with
    // the matching loads, so one table serves both.
    function automatic logic [2:0] align_mask(input logic [2:0] funct3);
        logic [2:0] mask;
        mask = 3'b000;
        case (funct3)
            F3_LH, F3_LHU: mask = 3'b001;
            F3_LW, F3_LWU: mask = 3'b011;
            F3_LD:         mask = 3'b111;
            default:       mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_align_chk.sv
// Combinational alignment check: flags an access whose low address bits
// are not a multiple of the access size given by funct3. Byte accesses
// (and any unused encoding) are never misaligned.
module mem_align_chk
    import mem_stage_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [2:0] addr_lo,
    output logic       misaligned
);

    assign misaligned = |(addr_lo & align_mask(funct3));

endmodule

// File: rtl/mem_stage.sv
// Memory-stage controller between execute and the load/store unit.
// Takes one instruction at a time, checks alignment, runs the LSU
// request/response handshake and hands the result or exception to
// writeback. An LSU access, once started, always runs to its response;
// a flush during an access only discards the result.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | empty, ready to accept from execute
//   ACCESS  | LSU request held high, waiting for the response
//   OUT     | result/exception held on the wb_* outputs until wb_ready
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,

    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [31:0]     ex_pc,
    input  logic [4:0]      ex_rd,
    input  logic            ex_rd_wen,
    input  logic            ex_mem_ren,
    input  logic            ex_mem_wen,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,

    output logic [2:0]      lsu_funct3,
    output logic [31:0]     lsu_addr,
    output logic            lsu_r_ready,
    input  logic            lsu_r_valid,
    input  logic [XLEN-1:0] lsu_r_data,
    output logic            lsu_w_valid,
    output logic [XLEN-1:0] lsu_w_data,
    input  logic            lsu_w_ready,

    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [31:0]     wb_pc,
    output logic [4:0]      wb_rd,
    output logic            wb_rd_wen,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_exc,
    output logic [3:0]      wb_exc_cause,
    output logic [31:0]     wb_tval
);

    mem_state_e state_q;
    mem_state_e state_d;
    logic       kill_q;
    logic       kill_d;
    logic       is_load_q;
    logic       is_store_q;

    logic       ex_misaligned;
    logic       ex_is_mem;
    logic       ex_mis_mem;
    logic       ex_aligned_mem;
    logic       accept;
    logic       in_access;
    logic       lsu_resp;
    mem_state_e accept_state;

    mem_align_chk u_align_chk (
        .funct3     (ex_funct3),
        .addr_lo    (ex_alu_result[2:0]),
        .misaligned (ex_misaligned)
    );

    assign ex_is_mem      = ex_mem_ren | ex_mem_wen;
    assign ex_mis_mem     = ex_is_mem & ex_misaligned;
    assign ex_aligned_mem = ex_is_mem & ~ex_misaligned;

    // Stage is free when empty, or when the held result leaves this cycle.
    assign ex_ready = (state_q == ST_IDLE) | ((state_q == ST_OUT) & wb_ready);
    assign accept   = ex_valid & ex_ready & ~flush;

    // Where a newly accepted instruction goes: only aligned memory ops
    // touch the LSU, everything else has its result ready immediately.
    assign accept_state = ex_aligned_mem ? ST_ACCESS : ST_OUT;

    // Requests come straight off the state register so that an async
    // reset drops them without waiting for a clock.
    assign in_access   = (state_q == ST_ACCESS);
    assign lsu_r_ready = in_access & is_load_q;
    assign lsu_w_valid = in_access & is_store_q;
    assign lsu_resp    = is_load_q ? lsu_r_valid : lsu_w_ready;

    assign wb_valid = (state_q == ST_OUT);

    // State and kill-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // Next-state logic; the kill flag only lives while an access is open.
    always_comb begin
        state_d = state_q;
        kill_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = accept_state;
                end
            end
            ST_ACCESS: begin
                if (lsu_resp) begin
                    // A flush arriving together with the response still kills.
                    state_d = (kill_q | flush) ? ST_IDLE : ST_OUT;
                end else begin
                    kill_d = kill_q | flush;
                end
            end
            ST_OUT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (wb_ready) begin
                    state_d = accept ? accept_state : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Instruction capture on acceptance and load-data capture on response.
    // LSU-facing fields only change on acceptance, which never happens in
    // ACCESS, so address and funct3 stay put for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            lsu_funct3   <= '0;
            lsu_addr     <= '0;
            lsu_w_data   <= '0;
            wb_pc        <= '0;
            wb_rd        <= '0;
            wb_rd_wen    <= 1'b0;
            wb_data      <= '0;
            wb_exc       <= 1'b0;
            wb_exc_cause <= '0;
            wb_tval      <= '0;
        end else if (accept) begin
            is_load_q    <= ex_mem_ren & ~ex_misaligned;
            is_store_q   <= ex_mem_wen & ~ex_misaligned;
            lsu_funct3   <= ex_funct3;
            lsu_addr     <= ex_alu_result[31:0];
            lsu_w_data   <= ex_store_data;
            wb_pc        <= ex_pc;
            wb_rd        <= ex_rd;
            // Stores and faulting accesses never write the register file.
            wb_rd_wen    <= ex_rd_wen & ~ex_mem_wen & ~ex_mis_mem;
            wb_data      <= ex_aligned_mem ? '0 : ex_alu_result;
            wb_exc       <= ex_mis_mem;
            if (ex_mis_mem) begin
                wb_exc_cause <= ex_mem_wen ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
                wb_tval      <= ex_alu_result[31:0];
            end else begin
                wb_exc_cause <= '0;
                wb_tval      <= '0;
            end
        end else if (in_access && is_load_q && lsu_r_valid) begin
            wb_data <= lsu_r_data;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios for the timing
// corners plus a randomized run against a behavioural reference model.
module tb_mem_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_ready;
    logic [31:0]     ex_pc = '0;
    logic [4:0]      ex_rd = '0;
    logic            ex_rd_wen = 1'b0;
    logic            ex_mem_ren = 1'b0;
    logic            ex_mem_wen = 1'b0;
    logic [2:0]      ex_funct3 = '0;
    logic [XLEN-1:0] ex_alu_result = '0;
    logic [XLEN-1:0] ex_store_data = '0;
    logic [2:0]      lsu_funct3;
    logic [31:0]     lsu_addr;
    logic            lsu_r_ready;
    logic            lsu_r_valid = 1'b0;
    logic [XLEN-1:0] lsu_r_data = '0;
    logic            lsu_w_valid;
    logic [XLEN-1:0] lsu_w_data;
    logic            lsu_w_ready = 1'b0;
    logic            wb_valid;
    logic            wb_ready = 1'b0;
    logic [31:0]     wb_pc;
    logic [4:0]      wb_rd;
    logic            wb_rd_wen;
    logic [XLEN-1:0] wb_data;
    logic            wb_exc;
    logic [3:0]      wb_exc_cause;
    logic [31:0]     wb_tval;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_rd_wen(ex_rd_wen), .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen),
        .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_r_ready(lsu_r_ready),
        .lsu_r_valid(lsu_r_valid), .lsu_r_data(lsu_r_data), .lsu_w_valid(lsu_w_valid),
        .lsu_w_data(lsu_w_data), .lsu_w_ready(lsu_w_ready),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_rd_wen(wb_rd_wen), .wb_data(wb_data), .wb_exc(wb_exc),
        .wb_exc_cause(wb_exc_cause), .wb_tval(wb_tval)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store
    task automatic put(input int kind, input logic [2:0] f3, input logic [63:0] alu,
                       input logic [63:0] sd, input logic [4:0] rd, input logic wen,
                       input logic [31:0] pc);
        ex_valid      = 1'b1;
        ex_mem_ren    = (kind == 1);
        ex_mem_wen    = (kind == 2);
        ex_funct3     = f3;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_rd_wen     = wen;
        ex_pc         = pc;
    endtask

    task automatic idle_ex();
        ex_valid   = 1'b0;
        ex_mem_ren = 1'b0;
        ex_mem_wen = 1'b0;
    endtask

    // Reference rule: an access of 2**funct3[1:0] bytes must sit on a
    // multiple of its own size.
    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned size;
        size = 32'd1 << f3[1:0];
        return (addr % size) != 0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid: got %0b want 0", wb_valid); end
        n_cmp++; if ({lsu_r_ready, lsu_w_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_lsu_req: got %b want 00", {lsu_r_ready, lsu_w_valid}); end
        n_cmp++; if (wb_data !== 64'd0 || wb_pc !== 32'd0 || wb_tval !== 32'd0 || lsu_addr !== 32'd0)
            begin n_bad++; $display("FAIL reset_regs: data %h pc %h tval %h addr %h want all 0", wb_data, wb_pc, wb_tval, lsu_addr); end
        n_cmp++; if ({wb_exc, wb_exc_cause, wb_rd_wen} !== 6'd0) begin n_bad++; $display("FAIL reset_exc: got %b want 0", {wb_exc, wb_exc_cause, wb_rd_wen}); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ex_ready: got %0b want 1", ex_ready); end
        cyc();
    endtask

    task automatic test_load_ld();
        int win;
        wb_ready = 1'b0;
        put(1, 3'b011, 64'h0000_0000_8000_0008, 64'h0, 5'd7, 1'b1, 32'h0000_0100);
        #1;
        n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL ld_ex_ready: got %0b want 1", ex_ready); end
        cyc();
        idle_ex();
        #1;
        win = 0;
        for (int i = 0; i < 3; i++) begin
            lsu_r_data = {$urandom, $urandom};
            if (lsu_r_ready === 1'b1) win++;
            n_cmp++; if (lsu_addr !== 32'h8000_0008 || lsu_funct3 !== 3'b011)
                begin n_bad++; $display("FAIL ld_addr_stable: addr %h f3 %0d want 80000008/3", lsu_addr, lsu_funct3); end
            n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL ld_wb_early: got %0b want 0", wb_valid); end
            cyc();
        end
        lsu_r_valid = 1'b1;
        lsu_r_data  = 64'h1122_3344_5566_7788;
        #1;
        if (lsu_r_ready === 1'b1) win++;
        cyc();
        lsu_r_valid = 1'b0;
        lsu_r_data  = 64'hdead_beef_dead_beef;
        #1;
        n_cmp++; if (win !== 4) begin n_bad++; $display("FAIL ld_req_window: got %0d cycles want 4", win); end
        n_cmp++; if (lsu_r_ready !== 1'b0) begin n_bad++; $display("FAIL ld_req_drop: got %0b want 0", lsu_r_ready); end
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL ld_wb_valid: got %0b want 1", wb_valid); end
        n_cmp++; if (wb_data !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL ld_wb_data: got %h want 1122334455667788", wb_data); end
        n_cmp++; if (wb_rd_wen !== 1'b1 || wb_rd !== 5'd7 || wb_pc !== 32'h100 || wb_exc !== 1'b0)
            begin n_bad++; $display("FAIL ld_wb_fields: wen %0b rd %0d pc %h exc %0b want 1/7/100/0", wb_rd_wen, wb_rd, wb_pc, wb_exc); end
        cyc();
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 64'h1122_3344_5566_7788 || lsu_r_ready !== 1'b0)
            begin n_bad++; $display("FAIL ld_hold: valid %0b data %h req %0b", wb_valid, wb_data, lsu_r_ready); end
        wb_ready = 1'b1;
        cyc();
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL ld_drain: got %0b want 0", wb_valid); end
        wb_ready = 1'b0;
    endtask

    task automatic test_misaligned_sw();
        wb_ready = 1'b0;
        put(2, 3'b010, 64'h0000_0000_8000_0006, 64'h1234, 5'd9, 1'b1, 32'h0000_0200);
        #1;
        n_cmp++; if (lsu_w_valid !== 1'b0) begin n_bad++; $display("FAIL sw_no_req0: got %0b want 0", lsu_w_valid); end
        cyc();
        idle_ex();
        #1;
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL sw_wb_valid: got %0b want 1", wb_valid); end
        n_cmp++; if (wb_exc !== 1'b1 || wb_exc_cause !== 4'd6) begin n_bad++; $display("FAIL sw_exc: exc %0b cause %0d want 1/6", wb_exc, wb_exc_cause); end
        n_cmp++; if (wb_tval !== 32'h8000_0006) begin n_bad++; $display("FAIL sw_tval: got %h want 80000006", wb_tval); end
        n_cmp++; if (wb_rd_wen !== 1'b0 || lsu_w_valid !== 1'b0) begin n_bad++; $display("FAIL sw_side: wen %0b wreq %0b want 0/0", wb_rd_wen, lsu_w_valid); end
        wb_ready = 1'b1;
        cyc();
        n_cmp++; if (wb_valid !== 1'b0 || lsu_w_valid !== 1'b0) begin n_bad++; $display("FAIL sw_drain: valid %0b wreq %0b want 0/0", wb_valid, lsu_w_valid); end
        wb_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            put(0, 3'b000, 64'(i), 64'h0, 5'd3, 1'b1, 32'(32'h300 + 4 * i));
            cyc();
            #1;
            n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 64'(i))
                begin n_bad++; $display("FAIL b2b_data%0d: valid %0b data %0d want 1/%0d", i, wb_valid, wb_data, i); end
        end
        put(0, 3'b000, 64'd5, 64'h0, 5'd3, 1'b1, 32'h314);
        wb_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_ready: got %0b want 0", ex_ready); end
            cyc();
            n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 64'd4)
                begin n_bad++; $display("FAIL b2b_hold: valid %0b data %0d want 1/4", wb_valid, wb_data); end
        end
        wb_ready = 1'b1;
        cyc();
        idle_ex();
        #1;
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 64'd5) begin n_bad++; $display("FAIL b2b_resume: valid %0b data %0d want 1/5", wb_valid, wb_data); end
        cyc();
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %0b want 0", wb_valid); end
        wb_ready = 1'b0;
    endtask

    task automatic test_flush_out();
        wb_ready = 1'b0;
        put(0, 3'b000, 64'h11, 64'h0, 5'd1, 1'b1, 32'h400);
        cyc();
        put(0, 3'b000, 64'h22, 64'h0, 5'd2, 1'b1, 32'h404);
        flush    = 1'b1;
        wb_ready = 1'b1;
        cyc();
        flush = 1'b0;
        idle_ex();
        #1;
        n_cmp++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin n_bad++; $display("FAIL flush_out: valid %0b ready %0b want 0/1", wb_valid, ex_ready); end
        cyc();
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_accept: got %0b want 0", wb_valid); end
        wb_ready = 1'b0;
    endtask

    task automatic test_flush_access();
        wb_ready = 1'b0;
        put(2, 3'b011, 64'h0000_0000_8000_0010, 64'hcafe_f00d_0123_4567, 5'd4, 1'b0, 32'h500);
        cyc();
        idle_ex();
        #1;
        n_cmp++; if (lsu_w_valid !== 1'b1 || lsu_w_data !== 64'hcafe_f00d_0123_4567)
            begin n_bad++; $display("FAIL fsd_req: wreq %0b data %h want 1/cafef00d01234567", lsu_w_valid, lsu_w_data); end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (lsu_w_valid !== 1'b1 || wb_valid !== 1'b0)
                begin n_bad++; $display("FAIL fsd_held: wreq %0b valid %0b want 1/0", lsu_w_valid, wb_valid); end
            cyc();
        end
        lsu_w_ready = 1'b1;
        #1;
        n_cmp++; if (lsu_w_valid !== 1'b1) begin n_bad++; $display("FAIL fsd_req_at_resp: got %0b want 1", lsu_w_valid); end
        cyc();
        lsu_w_ready = 1'b0;
        #1;
        n_cmp++; if (lsu_w_valid !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1)
            begin n_bad++; $display("FAIL fsd_after: wreq %0b valid %0b ready %0b want 0/0/1", lsu_w_valid, wb_valid, ex_ready); end
        wb_ready = 1'b1;
        put(0, 3'b000, 64'h77, 64'h0, 5'd5, 1'b1, 32'h504);
        cyc();
        idle_ex();
        #1;
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 64'h77) begin n_bad++; $display("FAIL fsd_next: valid %0b data %h want 1/77", wb_valid, wb_data); end
        cyc();
        wb_ready = 1'b0;
    endtask

    task automatic test_pulse_load();
        logic [63:0] d;
        int cnt;
        d = {$urandom, $urandom};
        wb_ready = 1'b0;
        put(1, 3'b010, 64'h0000_0000_8000_0004, 64'h0, 5'd11, 1'b1, 32'h600);
        cyc();
        idle_ex();
        #1;
        n_cmp++; if (lsu_r_ready !== 1'b1) begin n_bad++; $display("FAIL pulse_req: got %0b want 1", lsu_r_ready); end
        lsu_r_valid = 1'b1;
        lsu_r_data  = d;
        cyc();
        lsu_r_valid = 1'b0;
        lsu_r_data  = ~d;
        #1;
        n_cmp++; if (lsu_r_ready !== 1'b0 || wb_valid !== 1'b1 || wb_data !== d)
            begin n_bad++; $display("FAIL pulse_resp: req %0b valid %0b data %h want 0/1/%h", lsu_r_ready, wb_valid, wb_data, d); end
        cyc();
        n_cmp++; if (lsu_r_ready !== 1'b0) begin n_bad++; $display("FAIL pulse_reissue: got %0b want 0", lsu_r_ready); end
        wb_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (wb_valid === 1'b1 && wb_ready === 1'b1) cnt++;
            cyc();
        end
        n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL pulse_wb_count: got %0d want 1", cnt); end
        wb_ready = 1'b0;
    endtask

    task automatic test_reset_access();
        put(1, 3'b000, 64'h0000_0000_8000_0003, 64'h0, 5'd2, 1'b1, 32'h700);
        cyc();
        idle_ex();
        #1;
        n_cmp++; if (lsu_r_ready !== 1'b1) begin n_bad++; $display("FAIL rst_acc_req: got %0b want 1", lsu_r_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (lsu_r_ready !== 1'b0 || lsu_w_valid !== 1'b0)
            begin n_bad++; $display("FAIL rst_acc_async: rreq %0b wreq %0b want 0/0", lsu_r_ready, lsu_w_valid); end
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (ex_ready !== 1'b1 || wb_valid !== 1'b0 || lsu_r_ready !== 1'b0)
            begin n_bad++; $display("FAIL rst_acc_after: ready %0b valid %0b rreq %0b want 1/0/0", ex_ready, wb_valid, lsu_r_ready); end
        cyc();
    endtask

    task automatic test_random();
        int kind, lat, stall;
        logic [2:0]  f3;
        logic [63:0] alu, sd, rdata;
        logic [4:0]  rd;
        logic        wen, mis, access;
        logic [31:0] pc;
        logic [3:0]  exp_cause;
        logic [31:0] exp_tval;
        logic        exp_wen;
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 2);
            f3 = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            alu   = {$urandom, 32'h8000_0000 | ($urandom & 32'h0000_0fff)};
            sd    = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            rd    = 5'($urandom_range(0, 31));
            wen   = 1'($urandom_range(0, 1));
            pc    = $urandom & 32'hffff_fffc;
            mis       = (kind != 0) && model_misaligned(f3, alu[31:0]);
            access    = (kind != 0) && !mis;
            exp_cause = !mis ? 4'd0 : (kind == 2) ? 4'd6 : 4'd4;
            exp_tval  = mis ? alu[31:0] : 32'd0;
            exp_wen   = wen && !mis && (kind != 2);

            put(kind, f3, alu, sd, rd, wen, pc);
            #1;
            n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_ex_ready: got %0b want 1", k, ex_ready); end
            cyc();
            idle_ex();
            #1;
            if (access) begin
                lat = $urandom_range(0, 4);
                for (int i = 0; i <= lat; i++) begin
                    lsu_r_data = {$urandom, $urandom};
                    if (i == lat) begin
                        lsu_r_valid = (kind == 1);
                        lsu_w_ready = (kind == 2);
                        lsu_r_data  = (kind == 1) ? rdata : lsu_r_data;
                        #1;
                    end
                    n_cmp++; if (lsu_r_ready !== (kind == 1) || lsu_w_valid !== (kind == 2) || wb_valid !== 1'b0)
                        begin n_bad++; $display("FAIL rnd%0d_req: rreq %0b wreq %0b valid %0b kind %0d", k, lsu_r_ready, lsu_w_valid, wb_valid, kind); end
                    n_cmp++; if (lsu_addr !== alu[31:0] || lsu_funct3 !== f3 || (kind == 2 && lsu_w_data !== sd))
                        begin n_bad++; $display("FAIL rnd%0d_lsu_fields: addr %h f3 %0d wdata %h want %h/%0d/%h", k, lsu_addr, lsu_funct3, lsu_w_data, alu[31:0], f3, sd); end
                    cyc();
                end
                lsu_r_valid = 1'b0;
                lsu_w_ready = 1'b0;
                lsu_r_data  = ~rdata;
                #1;
            end
            n_cmp++; if (wb_valid !== 1'b1 || lsu_r_ready !== 1'b0 || lsu_w_valid !== 1'b0)
                begin n_bad++; $display("FAIL rnd%0d_wb_valid: valid %0b rreq %0b wreq %0b want 1/0/0", k, wb_valid, lsu_r_ready, lsu_w_valid); end
            n_cmp++; if (wb_exc !== mis || wb_exc_cause !== exp_cause || wb_tval !== exp_tval)
                begin n_bad++; $display("FAIL rnd%0d_exc: exc %0b cause %0d tval %h want %0b/%0d/%h", k, wb_exc, wb_exc_cause, wb_tval, mis, exp_cause, exp_tval); end
            n_cmp++; if (wb_rd_wen !== exp_wen || wb_rd !== rd || wb_pc !== pc)
                begin n_bad++; $display("FAIL rnd%0d_fields: wen %0b rd %0d pc %h want %0b/%0d/%h", k, wb_rd_wen, wb_rd, wb_pc, exp_wen, rd, pc); end
            if (kind == 0 || (kind == 1 && !mis)) begin
                n_cmp++; if (wb_data !== ((kind == 0) ? alu : rdata))
                    begin n_bad++; $display("FAIL rnd%0d_data: got %h want %h", k, wb_data, (kind == 0) ? alu : rdata); end
            end
            stall = $urandom_range(0, 2);
            for (int i = 0; i < stall; i++) begin
                cyc();
                n_cmp++; if (wb_valid !== 1'b1 || ex_ready !== 1'b0)
                    begin n_bad++; $display("FAIL rnd%0d_stall: valid %0b ready %0b want 1/0", k, wb_valid, ex_ready); end
            end
            wb_ready = 1'b1;
            cyc();
            wb_ready = 1'b0;
            #1;
            n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_drain: got %0b want 0", k, wb_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_load_ld();
        test_misaligned_sw();
        test_back_to_back();
        test_flush_out();
        test_flush_access();
        test_pulse_load();
        test_reset_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
